button_input_controller: RTL and testbench

BUTTON_INPUT_CONTROLLER -- requirements
Module: button_input_controller

---
 rtl/button_input_controller.sv | 93 +++++++++
 tb/tb_button_input_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_input_controller.sv
// button_input_controller: synchronizes buttons and switches, debounces the buttons, and
// exposes a level register and a sticky rising-edge event register on a read bus with irq.
module button_input_controller #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic        FEPU_BEPU_r,
    input  logic        addr,
    input  logic [3:0]  btn,
    input  logic [7:0]  SW,
    output logic [31:0] BEPU_FEPU_data,
    output logic        BEPU_FEPU_valid,
    output logic        irq
);
    localparam logic [0:0]       IDLE  = 1'b0;
    localparam logic [0:0]       COUNT = 1'b1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic [3:0]       btn_s1_q, btn_s2_q;
    logic [7:0]       sw_s1_q, sw_s2_q;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [3:0]       evt_q, evt_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             irq_q, irq_d;
    logic             rd;

    always_comb begin
        stable_d = stable_q;
        state_d  = state_q;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt[i] = ((state_q[i] == COUNT) ? cnt_q[i] : '0) + CNT_W'(1);
            cnt_d[i]   = '0;
            if (btn_s2_q[i] == stable_q[i]) begin
                state_d[i] = IDLE;
            end else if (cnt_nxt[i] == LIMIT) begin
                stable_d[i] = ~stable_q[i];
                state_d[i]  = IDLE;
            end else begin
                cnt_d[i]   = cnt_nxt[i];
                state_d[i] = COUNT;
            end
        end
    end

    // A newly accepted rising edge outranks a concurrent read-clear of the same bit
    always_comb begin
        rd      = select & FEPU_BEPU_r;
        evt_d   = (evt_q & ~((rd & addr) ? evt_q : 4'b0)) | (stable_d & ~stable_q);
        data_d  = rd ? (addr ? {28'b0, evt_q} : {20'b0, stable_q, sw_s2_q}) : 32'b0;
        valid_d = rd;
        irq_d   = |evt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            stable_q <= '0;
            state_q  <= {4{IDLE}};
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            evt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
            stable_q <= stable_d;
            state_q  <= state_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            evt_q    <= evt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            irq_q    <= irq_d;
        end
    end

    assign BEPU_FEPU_data  = data_q;
    assign BEPU_FEPU_valid = valid_q;
    assign irq             = irq_q;
endmodule

// File: tb/tb_button_input_controller.sv
// tb_button_input_controller: table-driven register reads, directed debounce/event/reset
// sequences, then random stimulus compared against a window-based reference model.
module tb_button_input_controller;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        select = 1'b0;
    logic        rd_r = 1'b0;
    logic        addr = 1'b0;
    logic [3:0]  btn = 4'h0;
    logic [7:0]  sw = 8'h0;
    logic [31:0] data;
    logic        valid, irq;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    button_input_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .select(select), .FEPU_BEPU_r(rd_r), .addr(addr),
        .btn(btn), .SW(sw), .BEPU_FEPU_data(data), .BEPU_FEPU_valid(valid), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a level flips once the synchronized input has disagreed with it
    // for DEB consecutive edges, i.e. DEB edges since it last agreed.
    logic [3:0]  m_s1 = 0, m_s2 = 0, m_stable = 0, m_evt = 0, m_ns, m_clr;
    logic [7:0]  m_sw1 = 0, m_sw2 = 0;
    logic [31:0] m_data = 0;
    logic        m_valid = 0, m_irq = 0, m_rd;
    int          last [4] = '{0, 0, 0, 0};
    int          n = 0;

    always @(posedge clk) begin
        n++;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_sw1 = 0; m_sw2 = 0; m_stable = 0; m_evt = 0;
            m_data = 0; m_valid = 0; m_irq = 0;
            for (int b = 0; b < 4; b++) last[b] = n;
        end else begin
            m_ns = m_stable;
            for (int b = 0; b < 4; b++) begin
                if (m_s2[b] == m_stable[b]) last[b] = n;
                else if (n - last[b] >= DEB) begin
                    m_ns[b] = ~m_stable[b];
                    last[b] = n;
                end
            end
            m_rd    = select & rd_r;
            m_clr   = (m_rd && addr) ? m_evt : 4'h0;
            m_data  = m_rd ? (addr ? {28'h0, m_evt} : {20'h0, m_stable, m_sw2}) : 32'h0;
            m_valid = m_rd;
            m_irq   = |m_evt;
            m_evt   = (m_evt & ~m_clr) | (m_ns & ~m_stable);
            m_stable = m_ns;
            m_s2 = m_s1; m_s1 = btn; m_sw2 = m_sw1; m_sw1 = sw;
        end
    end

    typedef struct {
        logic [7:0]  sw;
        logic        sel;
        logic        rd;
        logic        addr;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vec [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000000A5};
        vec[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000000};
        vec[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000};
        vec[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000};
        vec[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000000FF};
        vec[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000};
        vec[6] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000005A};

        sw = 8'hFF;
        btn = 4'hF;
        repeat (2) @(negedge clk);
        check("reset_data", data, 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        btn = 4'h0;
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sw = vec[i].sw;
            repeat (3) @(negedge clk);
            select = vec[i].sel; rd_r = vec[i].rd; addr = vec[i].addr;
            @(negedge clk);
            select = 0; rd_r = 0; addr = 0;
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vec[i].exp_valid));
            check($sformatf("vec%0d_data", i), data, vec[i].exp_data);
            @(negedge clk);
            check($sformatf("vec%0d_valid_drop", i), 32'(valid), 32'h0);
            check($sformatf("vec%0d_data_idle", i), data, 32'h0);
        end

        // btn[2] held: level rises on the 6th edge, irq one edge later
        sw = 8'h00;
        repeat (3) @(negedge clk);
        btn[2] = 1'b1;
        repeat (5) @(negedge clk);
        select = 1; rd_r = 1; addr = 0;
        @(negedge clk);
        check("hold_lvl_early", data, 32'h0);
        check("hold_valid_early", 32'(valid), 32'h1);
        check("hold_irq_early", 32'(irq), 32'h0);
        @(negedge clk);
        check("hold_lvl", data, 32'h00000400);
        check("hold_irq", 32'(irq), 32'h1);
        addr = 1;
        @(negedge clk);
        select = 0; rd_r = 0; addr = 0;
        check("hold_evt", data, 32'h4);
        check("hold_irq_still", 32'(irq), 32'h1);
        @(negedge clk);
        check("hold_valid_off", 32'(valid), 32'h0);
        check("hold_data_off", data, 32'h0);
        check("hold_irq_clr", 32'(irq), 32'h0);
        btn[2] = 1'b0;
        repeat (8) @(negedge clk);

        // 3-cycle glitch on btn[1] is rejected; btn[2] release sets no event
        btn[1] = 1'b1;
        repeat (3) @(negedge clk);
        btn[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("glitch_irq", 32'(irq), 32'h0);
        end
        select = 1; rd_r = 1; addr = 1;
        @(negedge clk);
        addr = 0;
        check("glitch_evt", data, 32'h0);
        check("glitch_evt_valid", 32'(valid), 32'h1);
        @(negedge clk);
        select = 0; rd_r = 0;
        check("glitch_lvl", data, 32'h0);

        // back-to-back event reads on btn[0]
        @(negedge clk);
        btn[0] = 1'b1;
        repeat (8) @(negedge clk);
        check("b2b_irq_pre", 32'(irq), 32'h1);
        select = 1; rd_r = 1; addr = 1;
        @(negedge clk);
        check("b2b_first", data, 32'h1);
        check("b2b_irq_first", 32'(irq), 32'h1);
        @(negedge clk);
        select = 0; rd_r = 0; addr = 0;
        check("b2b_second", data, 32'h0);
        check("b2b_second_valid", 32'(valid), 32'h1);
        check("b2b_irq_fall", 32'(irq), 32'h0);
        btn[0] = 1'b0;
        repeat (8) @(negedge clk);

        // btn[3] accepted on the same edge an event read is accepted
        btn[3] = 1'b1;
        repeat (5) @(negedge clk);
        select = 1; rd_r = 1; addr = 1;
        @(negedge clk);
        check("coincide_first", data, 32'h0);
        @(negedge clk);
        select = 0; rd_r = 0; addr = 0;
        check("coincide_second", data, 32'h8);
        btn[3] = 1'b0;
        repeat (8) @(negedge clk);

        // reset pulse while valid is high and btn[1] counter sits at 3
        btn[1] = 1'b1;
        repeat (4) @(negedge clk);
        select = 1; rd_r = 1; addr = 0;
        @(negedge clk);
        select = 0; rd_r = 0;
        check("rst_pre_valid", 32'(valid), 32'h1);
        rst = 1'b0;
        #1;
        check("rst_async_data", data, 32'h0);
        check("rst_async_valid", 32'(valid), 32'h0);
        check("rst_async_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_no_valid", 32'(valid), 32'h0);
        repeat (4) @(negedge clk);
        select = 1; rd_r = 1; addr = 0;
        @(negedge clk);
        check("rst_restart_early", data, 32'h0);
        @(negedge clk);
        addr = 1;
        check("rst_restart_lvl", data, 32'h00000200);
        check("rst_restart_irq", 32'(irq), 32'h1);
        @(negedge clk);
        select = 0; rd_r = 0; addr = 0;
        check("rst_restart_evt", data, 32'h2);
        btn[1] = 1'b0;
        repeat (8) @(negedge clk);

        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            check("rnd_valid", 32'(valid), 32'(m_valid));
            check("rnd_data", data, m_data);
            check("rnd_irq", 32'(irq), 32'(m_irq));
            rst = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
            select = 1'($urandom_range(0, 1));
            rd_r   = 1'($urandom_range(0, 1));
            addr   = 1'($urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
